vga_fb_write_arbiter: RTL and testbench

//   Shares the single VGA framebuffer write port (vga_wren_enable/vga_data_addr/vga_data_write

---
 rtl/vga_fb_write_arbiter_if.sv | 35 +++
 rtl/vga_fb_write_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_vga_fb_write_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_write_arbiter_if.sv
// Signal bundle between the pixel sources (processor stores, fill control) and the
// framebuffer write arbiter, including the framebuffer write port it drives.
interface vga_fb_write_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              fill_start;
  logic [ADDR_W-1:0] fill_base;
  logic [ADDR_W-1:0] fill_len;
  logic [DATA_W-1:0] fill_color;
  logic              clear_overflow;
  logic              fill_busy;
  logic              fill_done;
  logic              cpu_overflow;
  logic              fb_wren;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;

  modport master (
    output cpu_wren, cpu_addr, cpu_data,
    output fill_start, fill_base, fill_len, fill_color, clear_overflow,
    input  fill_busy, fill_done, cpu_overflow,
    input  fb_wren, fb_addr, fb_data
  );

  modport slave (
    input  cpu_wren, cpu_addr, cpu_data,
    input  fill_start, fill_base, fill_len, fill_color, clear_overflow,
    output fill_busy, fill_done, cpu_overflow,
    output fb_wren, fb_addr, fb_data
  );
endinterface

// File: rtl/vga_fb_write_arbiter.sv
// Shares the framebuffer write port between buffered processor pixel stores and a
// run-length fill engine, using round-robin arbitration when both want the slot.
module vga_fb_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FB_PIXELS  = 307200
) (
  input  logic                  clock,
  input  logic                  reset,
  vga_fb_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W:0]   FB_LIMIT = (ADDR_W+1)'(FB_PIXELS);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [PTR_W:0]    ONE_P    = (PTR_W+1)'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_e;

  logic              in_vld_q;
  logic [ADDR_W-1:0] in_addr_q;
  logic [DATA_W-1:0] in_data_q;

  logic [ENT_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              fifo_empty_s, fifo_full_s;
  logic              push_s, pop_s, drop_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_data_s;

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [ADDR_W:0]   fill_addr_s;
  logic              clip_s, done_s;

  logic              cpu_req_s, fill_req_s;
  logic              grant_cpu_s, grant_fill_s;
  logic              rr_fill_q, rr_fill_d;

  logic              fb_wren_q, fb_wren_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [DATA_W-1:0] fb_data_q, fb_data_d;
  logic              fill_busy_q, fill_done_q;
  logic              ovf_q, ovf_d;

  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign {head_addr_s, head_data_s} = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

  // Sum is one bit wider than an address so a run near the end never wraps to 0.
  assign fill_addr_s = {1'b0, base_q} + {1'b0, cnt_q};
  assign clip_s      = (fill_addr_s >= FB_LIMIT);

  // Request collection and round-robin grant; the pointer only moves on contention.
  always_comb begin
    cpu_req_s    = ~fifo_empty_s;
    fill_req_s   = (state_q == ST_RUN) && !clip_s;
    grant_cpu_s  = cpu_req_s && (!fill_req_s || !rr_fill_q);
    grant_fill_s = fill_req_s && (!cpu_req_s || rr_fill_q);
    if (cpu_req_s && fill_req_s) begin
      rr_fill_d = ~rr_fill_q;
    end else begin
      rr_fill_d = rr_fill_q;
    end
  end

  // FIFO pointer update; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    pop_s    = grant_cpu_s;
    push_s   = in_vld_q && (!fifo_full_s || pop_s);
    drop_s   = in_vld_q && fifo_full_s && !pop_s;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ONE_P;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ONE_P;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Fill engine next state.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    done_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.fill_start && (bus.fill_len != {ADDR_W{1'b0}})) begin
          base_d  = bus.fill_base;
          len_d   = bus.fill_len;
          color_d = bus.fill_color;
          cnt_d   = {ADDR_W{1'b0}};
          state_d = ST_RUN;
        end else if (bus.fill_start) begin
          done_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (clip_s) begin
          state_d = ST_IDLE;
          done_s  = 1'b1;
        end else if (grant_fill_s && (cnt_q == len_q - ONE_A)) begin
          state_d = ST_IDLE;
          done_s  = 1'b1;
        end else if (grant_fill_s) begin
          cnt_d = cnt_q + ONE_A;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Framebuffer port next values; address/data hold while idle, and out-of-range CPU slots are burnt silently.
  always_comb begin
    fb_wren_d = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    if (grant_fill_s) begin
      fb_wren_d = 1'b1;
      fb_addr_d = fill_addr_s[ADDR_W-1:0];
      fb_data_d = color_q;
    end else if (grant_cpu_s && ({1'b0, head_addr_s} < FB_LIMIT)) begin
      fb_wren_d = 1'b1;
      fb_addr_d = head_addr_s;
      fb_data_d = head_data_s;
    end else begin
      fb_wren_d = 1'b0;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (bus.clear_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {in_addr_q, in_data_q};
    end
  end

  // Control and output registers; the input stage gives CPU writes their fixed latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_vld_q    <= 1'b0;
      in_addr_q   <= {ADDR_W{1'b0}};
      in_data_q   <= {DATA_W{1'b0}};
      wr_ptr_q    <= {(PTR_W+1){1'b0}};
      rd_ptr_q    <= {(PTR_W+1){1'b0}};
      state_q     <= ST_IDLE;
      base_q      <= {ADDR_W{1'b0}};
      len_q       <= {ADDR_W{1'b0}};
      cnt_q       <= {ADDR_W{1'b0}};
      color_q     <= {DATA_W{1'b0}};
      rr_fill_q   <= 1'b0;
      fb_wren_q   <= 1'b0;
      fb_addr_q   <= {ADDR_W{1'b0}};
      fb_data_q   <= {DATA_W{1'b0}};
      fill_busy_q <= 1'b0;
      fill_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      in_vld_q    <= bus.cpu_wren;
      in_addr_q   <= bus.cpu_addr;
      in_data_q   <= bus.cpu_data;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      color_q     <= color_d;
      rr_fill_q   <= rr_fill_d;
      fb_wren_q   <= fb_wren_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      fill_busy_q <= (state_d == ST_RUN);
      fill_done_q <= done_s;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.fb_wren      = fb_wren_q;
  assign bus.fb_addr      = fb_addr_q;
  assign bus.fb_data      = fb_data_q;
  assign bus.fill_busy    = fill_busy_q;
  assign bus.fill_done    = fill_done_q;
  assign bus.cpu_overflow = ovf_q;
endmodule

// File: tb/tb_vga_fb_write_arbiter.sv
// Randomized self-checking bench: framebuffer writes are logged and compared with the
// expected per-source write streams, latencies and arbitration rules.
module tb_vga_fb_write_arbiter;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 8;
  localparam int FB_PIXELS = 307200;
  localparam int CPU_BASE  = 100000;

  typedef struct { int addr; int data; int cyc; } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0, checks = 0, cyc = 0, done_cnt = 0, done_cyc = 0, cpu_seq = 0;
  wr_t  wq[$], fq[$], cq[$];
  int   exp_a[$], exp_d[$];

  vga_fb_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_fb_write_arbiter #(
    .FIFO_DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_PIXELS(FB_PIXELS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.fb_wren === 1'b1) wq.push_back('{int'(bus.fb_addr), int'(bus.fb_data), cyc});
    if (bus.fill_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic step(); @(posedge clock); #1; endtask

  task automatic idle_inputs();
    bus.cpu_wren = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.fill_start = 1'b0; bus.fill_base = '0; bus.fill_len = '0; bus.fill_color = '0;
    bus.clear_overflow = 1'b0;
  endtask

  task automatic clear_log(); wq.delete(); done_cnt = 0; exp_a.delete(); exp_d.delete(); endtask

  task automatic split_log(input int thr);
    fq.delete(); cq.delete();
    foreach (wq[i]) if (wq[i].addr < thr) fq.push_back(wq[i]); else cq.push_back(wq[i]);
  endtask

  task automatic start_fill(input int base, input int len, input int color);
    bus.fill_start = 1'b1; bus.fill_base = ADDR_W'(base);
    bus.fill_len = ADDR_W'(len); bus.fill_color = DATA_W'(color);
  endtask

  task automatic cpu_issue(input int a, input int d);
    bus.cpu_wren = 1'b1; bus.cpu_addr = ADDR_W'(a); bus.cpu_data = DATA_W'(d);
    if (a < FB_PIXELS) begin exp_a.push_back(a); exp_d.push_back(d & 255); end
  endtask

  task automatic wait_fill_idle(input int budget);
    int n = 0;
    while (bus.fill_busy === 1'b1 && n < budget) begin step(); n++; end
    checks++;
    if (n >= budget) begin errors++; $display("FAIL fill_timeout: busy=%b after %0d cycles, required 0", bus.fill_busy, n); end
    repeat (8) step();
  endtask

  function automatic int fill_bad(input int base, input int n, input int color);
    int bad;
    bad = (fq.size() != n) ? 1 : 0;
    for (int i = 0; i < fq.size() && i < n; i++)
      if (fq[i].addr != base + i || fq[i].data != (color & 255)) bad++;
    return bad;
  endfunction

  function automatic int cpu_exact_bad();
    int bad;
    bad = (cq.size() != exp_a.size()) ? 1 : 0;
    for (int i = 0; i < cq.size() && i < exp_a.size(); i++)
      if (cq[i].addr != exp_a[i] || cq[i].data != exp_d[i]) bad++;
    return bad;
  endfunction

  function automatic int cpu_subseq_bad();
    int j = 0;
    int bad = 0;
    foreach (cq[i]) begin
      while (j < exp_a.size() && (exp_a[j] != cq[i].addr || exp_d[j] != cq[i].data)) j++;
      if (j >= exp_a.size()) bad++; else j++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); repeat (3) step();
    checks++;
    if ({bus.fb_wren, bus.fill_busy, bus.fill_done, bus.cpu_overflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: wren/busy/done/ovf=%b, required 0000",
                         {bus.fb_wren, bus.fill_busy, bus.fill_done, bus.cpu_overflow}); end
    checks++;
    if (bus.fb_addr !== 19'd0 || bus.fb_data !== 8'd0) begin
      errors++; $display("FAIL reset_bus: addr=%0d data=%0d, required 0 0", bus.fb_addr, bus.fb_data); end
    reset = 1'b0; step();
    start_fill(20, 200, 8'h5A); step(); bus.fill_start = 1'b0;
    for (int j = 0; j < 3; j++) begin cpu_issue(3000 + j, j); step(); end
    checks++;
    if (bus.fill_busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: busy=%b, required 1", bus.fill_busy); end
    reset = 1'b1; idle_inputs(); step(); clear_log(); repeat (2) step();
    checks++;
    if ({bus.fb_wren, bus.fill_busy, bus.fill_done, bus.cpu_overflow} !== 4'b0000 ||
        bus.fb_addr !== 19'd0 || bus.fb_data !== 8'd0) begin
      errors++; $display("FAIL reset_mid: flags=%b addr=%0d data=%0d, required all 0",
                         {bus.fb_wren, bus.fill_busy, bus.fill_done, bus.cpu_overflow}, bus.fb_addr, bus.fb_data); end
    reset = 1'b0; repeat (12) step();
    checks++;
    if (wq.size() != 0 || done_cnt != 0 || bus.fill_busy !== 1'b0) begin
      errors++; $display("FAIL reset_after: writes=%0d done=%0d busy=%b, required 0 0 0", wq.size(), done_cnt, bus.fill_busy); end
  endtask

  task automatic test_cpu_single();
    int t0;
    clear_log(); cpu_issue(32'h100, 32'h3C); t0 = cyc; step(); bus.cpu_wren = 1'b0; repeat (6) step();
    checks++;
    if (wq.size() != 1) begin errors++; $display("FAIL cpu_count: %0d writes, required 1", wq.size()); end
    else begin
      checks++;
      if (wq[0].addr != 32'h100 || wq[0].data != 32'h3C) begin
        errors++; $display("FAIL cpu_value: addr=%h data=%h, required 00100 3c", wq[0].addr, wq[0].data); end
      checks++;
      if (wq[0].cyc != t0 + 3) begin errors++; $display("FAIL cpu_latency: cycle %0d, required %0d", wq[0].cyc, t0 + 3); end
    end
    checks++;
    if (bus.fb_wren !== 1'b0 || bus.fb_addr !== 19'h00100 || bus.fb_data !== 8'h3C) begin
      errors++; $display("FAIL cpu_hold: wren=%b addr=%h data=%h, required 0 00100 3c", bus.fb_wren, bus.fb_addr, bus.fb_data); end
  endtask

  task automatic test_invalid_addr();
    int t0;
    clear_log(); t0 = cyc;
    cpu_issue(FB_PIXELS, 32'hAA); step();
    cpu_issue(32'h7FFFF, 32'hBB); step();
    cpu_issue(32'h200, 32'h55); step();
    bus.cpu_wren = 1'b0; repeat (8) step();
    checks++;
    if (wq.size() != 1) begin errors++; $display("FAIL invalid_count: %0d writes, required 1", wq.size()); end
    else begin
      checks++;
      if (wq[0].addr != 32'h200 || wq[0].data != 32'h55 || wq[0].cyc != t0 + 5) begin
        errors++; $display("FAIL invalid_next: addr=%h data=%h cyc=%0d, required 00200 55 %0d",
                           wq[0].addr, wq[0].data, wq[0].cyc, t0 + 5); end
    end
  endtask

  task automatic test_fill_basic();
    int t0, bad;
    clear_log(); start_fill(0, 4, 32'hFF); t0 = cyc; step(); bus.fill_start = 1'b0;
    wait_fill_idle(20);
    bad = (wq.size() != 4) ? 1 : 0;
    for (int i = 0; i < wq.size() && i < 4; i++)
      if (wq[i].addr != i || wq[i].data != 32'hFF || wq[i].cyc != t0 + 2 + i) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fill_basic_seq: %0d writes %0d bad, required addr 0..3 on cycles %0d..%0d",
                                         wq.size(), bad, t0 + 2, t0 + 5); end
    checks++;
    if (done_cnt != 1 || done_cyc != t0 + 5) begin
      errors++; $display("FAIL fill_basic_done: count=%0d cyc=%0d, required 1 at %0d", done_cnt, done_cyc, t0 + 5); end
    checks++;
    if (bus.fill_busy !== 1'b0) begin errors++; $display("FAIL fill_basic_busy: busy=%b, required 0", bus.fill_busy); end
  endtask

  task automatic test_contention();
    int t0, col, last, viol, side_prev;
    bit both_prev;
    clear_log(); col = $urandom_range(0, 255);
    start_fill(100, 8, col); t0 = cyc;
    for (int j = 0; j < 6; j++) begin cpu_issue(500 + j, $urandom_range(0, 255)); step(); bus.fill_start = 1'b0; end
    bus.cpu_wren = 1'b0; wait_fill_idle(40);
    split_log(400);
    checks++;
    if (fill_bad(100, 8, col) != 0) begin errors++; $display("FAIL cont_fill: %0d fill writes, required 100..107", fq.size()); end
    checks++;
    if (cpu_exact_bad() != 0) begin errors++; $display("FAIL cont_cpu: %0d cpu writes, required 6 in order", cq.size()); end
    checks++;
    if (bus.cpu_overflow !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL cont_status: ovf=%b done=%0d, required 0 1", bus.cpu_overflow, done_cnt); end
    // A slot with work pending must be used; two pending sides never see the same winner twice running.
    last = 0; foreach (wq[i]) if (wq[i].cyc > last) last = wq[i].cyc;
    viol = 0; both_prev = 1'b0; side_prev = -1;
    for (int t = t0 + 2; t <= last; t++) begin
      bit fp, cp;
      int side;
      fp = (fq.size() > 0) && (t <= fq[$].cyc);
      cp = 1'b0;
      foreach (cq[j]) if (t0 + j + 3 <= t && cq[j].cyc >= t) cp = 1'b1;
      side = -1;
      foreach (wq[i]) if (wq[i].cyc == t) side = (wq[i].addr < 400) ? 1 : 0;
      if ((fp || cp) && side < 0) viol++;
      if (fp && cp && both_prev && side == side_prev) viol++;
      both_prev = fp && cp; side_prev = side;
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL cont_fairness: %0d slot violations, required 0", viol); end
  endtask

  task automatic test_overflow();
    int col;
    clear_log(); col = $urandom_range(0, 255);
    start_fill(1000, 60, col); step(); bus.fill_start = 1'b0; step();
    for (int j = 0; j < 12; j++) begin cpu_issue(2000 + j, $urandom_range(0, 255)); step(); end
    bus.cpu_wren = 1'b0; wait_fill_idle(150);
    split_log(1500);
    checks++;
    if (fill_bad(1000, 60, col) != 0) begin errors++; $display("FAIL ovf_fill: %0d fill writes, required 1000..1059", fq.size()); end
    // Half the slots go to the fill, so 9 or 10 of the 12 fit depending on the pointer phase.
    checks++;
    if (cq.size() < 9 || cq.size() > 10 || cpu_subseq_bad() != 0) begin
      errors++; $display("FAIL ovf_cpu: %0d cpu writes (%0d out of order), required 9..10 in order", cq.size(), cpu_subseq_bad()); end
    checks++;
    if (bus.cpu_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: ovf=%b, required 1", bus.cpu_overflow); end
    bus.clear_overflow = 1'b1; step(); bus.clear_overflow = 1'b0;
    checks++;
    if (bus.cpu_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: ovf=%b, required 0", bus.cpu_overflow); end
  endtask

  task automatic test_clip();
    int t0, col;
    clear_log(); col = $urandom_range(0, 255);
    start_fill(307198, 5, col); step(); bus.fill_start = 1'b0; wait_fill_idle(20);
    split_log(FB_PIXELS);
    checks++;
    if (fill_bad(307198, 2, col) != 0 || wq.size() != 2) begin
      errors++; $display("FAIL clip_writes: %0d writes, required 307198 307199 only", wq.size()); end
    checks++;
    if (done_cnt != 1 || bus.fill_busy !== 1'b0) begin
      errors++; $display("FAIL clip_done: done=%0d busy=%b, required 1 0", done_cnt, bus.fill_busy); end
    clear_log(); start_fill(50, 0, col); t0 = cyc; step(); bus.fill_start = 1'b0; repeat (5) step();
    checks++;
    if (done_cnt != 1 || done_cyc != t0 + 1 || wq.size() != 0) begin
      errors++; $display("FAIL zero_len: done=%0d at %0d writes=%0d, required 1 at %0d, 0 writes",
                         done_cnt, done_cyc, wq.size(), t0 + 1); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int base, len, col;
      clear_log();
      bus.clear_overflow = 1'b1; step(); bus.clear_overflow = 1'b0;
      base = $urandom_range(0, 50000); len = $urandom_range(6, 20); col = $urandom_range(0, 255);
      start_fill(base, len, col); step();
      for (int t = 0; t < 2 * len + 12; t++) begin
        if (t == 3) start_fill(60000, 3, 32'h11); else bus.fill_start = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 7) == 0) cpu_issue(FB_PIXELS + $urandom_range(0, 200000), $urandom_range(0, 255));
          else begin cpu_issue(CPU_BASE + cpu_seq, $urandom_range(0, 255)); cpu_seq++; end
        end else bus.cpu_wren = 1'b0;
        step();
      end
      bus.cpu_wren = 1'b0; bus.fill_start = 1'b0; wait_fill_idle(100);
      split_log(CPU_BASE);
      checks++;
      if (fill_bad(base, len, col) != 0 || done_cnt != 1) begin
        errors++; $display("FAIL rand_fill r%0d: %0d writes done=%0d, required %0d from %0d and 1 done",
                           r, fq.size(), done_cnt, len, base); end
      checks++;
      if ((bus.cpu_overflow === 1'b0) ? (cpu_exact_bad() != 0) : (cpu_subseq_bad() != 0)) begin
        errors++; $display("FAIL rand_cpu r%0d: %0d cpu writes ovf=%b, required %0d in order",
                           r, cq.size(), bus.cpu_overflow, exp_a.size()); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_single();
    test_invalid_addr();
    test_fill_basic();
    test_contention();
    test_overflow();
    test_clip();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
